// File: rtl/tnn_pkg.sv
// ---------------------------------------------------------------------------
// tnn_pkg
//
// Shared definitions for the sequential TNN threshold neuron:
//   - state_e   : neuron control states (collecting beats / holding decision)
//   - acc_width : accumulator width, wide enough for N_IN*(2^IN_W-1)
//   - cnt_width : beat counter width
// ---------------------------------------------------------------------------
package tnn_pkg;

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,  // accepting activation beats
        ST_OUT = 1'b1   // presenting the decision, waiting for out_ready
    } state_e;

    // IN_W + clog2(N_IN) bits always hold N_IN*(2^IN_W-1), so the sum never wraps.
    function automatic int acc_width(input int in_w, input int n_in);
        return in_w + $clog2(n_in);
    endfunction

    // Beat counter width; never below one bit even for degenerate fan-in.
    function automatic int cnt_width(input int n_in);
        return (n_in < 2) ? 1 : $clog2(n_in);
    endfunction

endpackage : tnn_pkg

// File: rtl/tnn_seq_neuron_if.sv
// ---------------------------------------------------------------------------
// tnn_seq_neuron_if
//
// Bundles the neuron's streaming and configuration signals.
//   thr_we / thr_in        : threshold write strobe and value (ACC_W bits)
//   in_valid/in_ready/in_data : activation beat handshake (IN_W-bit beats)
//   pol                    : per-beat polarity vector (N_IN bits)
//   out_valid/out_ready/out_bit : decision handshake
//
// Modports:
//   master : the side feeding activations and consuming decisions
//   slave  : the neuron itself
// ---------------------------------------------------------------------------
interface tnn_seq_neuron_if
    import tnn_pkg::*;
#(
    parameter int IN_W = 3,
    parameter int N_IN = 3
);

    localparam int ACC_W = acc_width(IN_W, N_IN);

    logic             thr_we;
    logic [ACC_W-1:0] thr_in;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [N_IN-1:0]  pol;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;

    modport master (
        output thr_we,
        output thr_in,
        output in_valid,
        input  in_ready,
        output in_data,
        output pol,
        input  out_valid,
        output out_ready,
        input  out_bit
    );

    modport slave (
        input  thr_we,
        input  thr_in,
        input  in_valid,
        output in_ready,
        input  in_data,
        input  pol,
        output out_valid,
        input  out_ready,
        output out_bit
    );

endinterface : tnn_seq_neuron_if

// File: rtl/tnn_beat_term.sv
// ---------------------------------------------------------------------------
// tnn_beat_term
//
// Combinational term generator: turns one activation beat into the value
// added to the accumulator.
//   in_data_i : IN_W-bit unsigned activation
//   pol_bit_i : polarity bit for this beat
//   term_o    : ACC_W-bit zero-extended term
//
// Build option TNN_NEURON_POL_EN: when defined, a beat whose polarity bit is
// 1 is bitwise-inverted (2^IN_W-1 - in_data). When undefined the polarity bit
// is ignored and the term is the activation itself.
// ---------------------------------------------------------------------------
module tnn_beat_term
    import tnn_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int ACC_W = 5
) (
    input  logic [IN_W-1:0]  in_data_i,
    input  logic             pol_bit_i,
    output logic [ACC_W-1:0] term_o
);

    logic [IN_W-1:0] beat_val;

`ifdef TNN_NEURON_POL_EN
    // Bitwise inversion of an unsigned IN_W value equals (2^IN_W-1) - value.
    assign beat_val = pol_bit_i ? ~in_data_i : in_data_i;
`else
    logic unused_pol;
    assign unused_pol = pol_bit_i;
    assign beat_val   = in_data_i;
`endif

    assign term_o = ACC_W'(beat_val);

endmodule : tnn_beat_term

// File: rtl/tnn_seq_neuron.sv
// ---------------------------------------------------------------------------
// tnn_seq_neuron
//
// Sequential threshold neuron: accumulates N_IN unsigned IN_W-bit beats, one
// per cycle, and presents a single decision bit (sum >= thr) on an output
// handshake. A threshold register, reset to THR_RST, can be rewritten at any
// time through thr_we/thr_in.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : tnn_seq_neuron_if.slave (threshold write, activation beats,
//          polarity vector, decision handshake)
//
// Build option TNN_NEURON_POL_EN enables per-beat polarity inversion
// (see tnn_beat_term); the default build ignores bus.pol.
//
// Timing: one beat per cycle while collecting; the decision is valid the
// cycle after the final beat; the cycle of the decision handshake has
// in_ready low, so a vector takes at least N_IN+1 cycles. All handshake
// outputs decode registered state only.
// ---------------------------------------------------------------------------
module tnn_seq_neuron
    import tnn_pkg::*;
#(
    parameter int IN_W    = 3,
    parameter int N_IN    = 3,
    parameter int THR_RST = 11
) (
    input  logic              clk,
    input  logic              rst,
    tnn_seq_neuron_if.slave   bus
);

    localparam int ACC_W = acc_width(IN_W, N_IN);
    localparam int CNT_W = cnt_width(N_IN);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);
    localparam logic [ACC_W-1:0] THR_INIT = ACC_W'(THR_RST);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [ACC_W-1:0] acc_q,     acc_d;
    logic [ACC_W-1:0] thr_q,     thr_d;
    logic             out_bit_q, out_bit_d;

    // -----------------------------------------------------------------------
    // Term generation for the current beat
    // -----------------------------------------------------------------------
    logic             pol_bit;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] sum;
    logic             beat_fire;

    // cnt_q never exceeds N_IN-1, so the index stays inside pol.
    assign pol_bit = bus.pol[cnt_q];

    tnn_beat_term #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_beat_term (
        .in_data_i (bus.in_data),
        .pol_bit_i (pol_bit),
        .term_o    (term)
    );

    assign sum       = acc_q + term;
    assign beat_fire = (state_q == ST_ACC) && bus.in_valid;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets its hold value first; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        out_bit_d = out_bit_q;

        // Comparison below uses thr_q, so a write in the final-beat cycle
        // only affects later vectors.
        thr_d = bus.thr_we ? bus.thr_in : thr_q;

        unique case (state_q)
            ST_ACC: begin
                if (beat_fire) begin
                    if (cnt_q == CNT_LAST) begin
                        out_bit_d = (sum >= thr_q);
                        state_d   = ST_OUT;
                        cnt_d     = '0;
                        acc_d     = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACC;
            cnt_q     <= '0;
            acc_q     <= '0;
            thr_q     <= THR_INIT;
            out_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            thr_q     <= thr_d;
            out_bit_q <= out_bit_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: pure decodes of registered state
    // -----------------------------------------------------------------------
    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_bit   = out_bit_q;

endmodule : tnn_seq_neuron

// File: tb/tb_tnn_seq_neuron.sv
// ---------------------------------------------------------------------------
// tb_tnn_seq_neuron
//
// Directed bench for tnn_seq_neuron with default parameters
// (IN_W=3, N_IN=3, THR_RST=11). A table of three-beat vectors with
// hand-computed decisions is applied in a loop, followed by hand-written
// sequences for back-pressure, mid-vector reset and threshold-write timing.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_tnn_seq_neuron;

    localparam int IN_W = 3;
    localparam int N_IN = 3;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    tnn_seq_neuron_if #(.IN_W(IN_W), .N_IN(N_IN)) bus ();

    tnn_seq_neuron #(
        .IN_W    (IN_W),
        .N_IN    (N_IN),
        .THR_RST (11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string    name;
        logic [2:0] b0;
        logic [2:0] b1;
        logic [2:0] b2;
        logic [2:0] pol;
        logic       exp_bit;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted beat, optionally with a threshold write in the same cycle.
    task automatic send_beat(input logic [2:0] data, input logic we, input logic [4:0] thr);
        check("in_ready_before_beat", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.thr_we   = we;
        bus.thr_in   = thr;
        tick();
        bus.in_valid = 1'b0;
        bus.thr_we   = 1'b0;
    endtask

    // Called right after the final beat: decision must be visible now; then
    // completes the output handshake with out_ready high.
    task automatic finish_vector(input string name, input logic exp_bit);
        check({name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_out_bit"},   32'(bus.out_bit),   32'(exp_bit));
        check({name, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        check({name, "_out_valid_clr"}, 32'(bus.out_valid), 32'd0);
        check({name, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_vector(input string name, input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] c, input logic [2:0] p, input logic exp_bit);
        bus.out_ready = 1'b1;
        bus.pol       = p;
        send_beat(a, 1'b0, 5'd0);
        send_beat(b, 1'b0, 5'd0);
        send_beat(c, 1'b0, 5'd0);
        finish_vector(name, exp_bit);
    endtask

    initial begin
        vecs[0] = '{"v_3_4_4",   3'd3, 3'd4, 3'd4, 3'b000, 1'b1};  // 11 >= 11
        vecs[1] = '{"v_3_4_3",   3'd3, 3'd4, 3'd3, 3'b000, 1'b0};  // 10 <  11
        vecs[2] = '{"v_7_7_7",   3'd7, 3'd7, 3'd7, 3'b000, 1'b1};  // 21, no wrap
        vecs[3] = '{"v_0_0_0",   3'd0, 3'd0, 3'd0, 3'b000, 1'b0};  // 0
        vecs[4] = '{"v_4_4_3",   3'd4, 3'd4, 3'd3, 3'b000, 1'b1};  // 11 exact
`ifdef TNN_NEURON_POL_EN
        vecs[5] = '{"v_pol_044", 3'd0, 3'd4, 3'd4, 3'b001, 1'b1};  // 7+4+4=15
`else
        vecs[5] = '{"v_pol_044", 3'd0, 3'd4, 3'd4, 3'b001, 1'b0};  // 0+4+4=8
`endif

        rst           = 1'b1;
        bus.thr_we    = 1'b0;
        bus.thr_in    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.pol       = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_bit",   32'(bus.out_bit),   32'd0);

        // Table-driven vectors, back-to-back.
        for (int i = 0; i < 6; i++) begin
            run_vector(vecs[i].name, vecs[i].b0, vecs[i].b1, vecs[i].b2,
                       vecs[i].pol, vecs[i].exp_bit);
        end
        bus.pol = '0;

        // Back-pressure: decision held for 5 cycles; beats offered meanwhile
        // must be ignored.
        bus.out_ready = 1'b0;
        send_beat(3'd3, 1'b0, 5'd0);
        send_beat(3'd4, 1'b0, 5'd0);
        send_beat(3'd4, 1'b0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_out_bit",   32'(bus.out_bit),   32'd1);
            check("hold_in_ready",  32'(bus.in_ready),  32'd0);
            bus.in_valid = 1'b1;
            bus.in_data  = 3'd7;
            tick();
        end
        check("hold_out_valid_last", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("release_in_ready",  32'(bus.in_ready),  32'd1);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        run_vector("after_hold_1_1_1", 3'd1, 3'd1, 3'd1, 3'b000, 1'b0);

        // Mid-vector reset: leave out_bit=1, lower thr to 3, take two beats,
        // then reset. Partial sum, out_bit and thr must all return to reset.
        run_vector("pre_rst_7_7_7", 3'd7, 3'd7, 3'd7, 3'b000, 1'b1);
        bus.thr_we = 1'b1;
        bus.thr_in = 5'd3;
        tick();
        bus.thr_we = 1'b0;
        send_beat(3'd7, 1'b0, 5'd0);
        send_beat(3'd7, 1'b0, 5'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_bit",   32'(bus.out_bit),   32'd0);
        run_vector("post_rst_1_1_1", 3'd1, 3'd1, 3'd1, 3'b000, 1'b0);

        // Threshold write on the first beat applies to this vector's decision.
        bus.out_ready = 1'b1;
        send_beat(3'd1, 1'b1, 5'd3);
        send_beat(3'd1, 1'b0, 5'd0);
        send_beat(3'd1, 1'b0, 5'd0);
        finish_vector("thr_first_beat", 1'b1);

        // Threshold write on the final beat: old thr (3) decides this vector,
        // new thr (20) decides the next ones.
        send_beat(3'd1, 1'b0, 5'd0);
        send_beat(3'd1, 1'b0, 5'd0);
        send_beat(3'd1, 1'b1, 5'd20);
        finish_vector("thr_final_beat_old", 1'b1);
        run_vector("thr_new_19", 3'd7, 3'd7, 3'd5, 3'b000, 1'b0);
        run_vector("thr_new_21", 3'd7, 3'd7, 3'd7, 3'b000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected completion before 100000");
        $fatal(1, "timeout");
    end

endmodule : tb_tnn_seq_neuron

// File: doc/tnn_seq_neuron.md
# tnn_seq_neuron

Sequential, parametrised threshold neuron for the TNN datapath: accepts an N_IN-element vector of IN_W-bit activations one element per beat, accumulates the exact sum, and emits a single-bit decision `sum >= thr`. It replaces fixed 3x3-bit combinational neuron cells where area matters more than throughput. It sits between the activation stream source and the next TNN layer, with valid/ready handshakes on both sides.

## Interface
- IN_W, 3, activation width in bits (>=1)
- N_IN, 3, beats per vector (fan-in, >=2)
- THR_RST, 11, threshold value loaded at reset
- ACC_W (derived, not overridable), IN_W + $clog2(N_IN), accumulator width; holds N_IN*(2^IN_W-1) without overflow
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- thr_we  in  1  threshold write strobe
- thr_in  in  ACC_W  new threshold, captured when thr_we=1
- in_valid  in  1  activation beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  IN_W  activation, unsigned
- pol  in  N_IN  per-beat polarity (used only with TNN_NEURON_POL_EN; ignored otherwise)
- out_valid  out  1  decision valid
- out_ready  in  1  consumer accepts decision
- out_bit  out  1  decision, 1 when sum >= thr

## Operation
- States: ACC (collecting beats), OUT (holding decision).
- ACC: in_ready=1, out_valid=0. On in_valid&in_ready: acc <= acc + term, cnt <= cnt+1. On the beat where cnt==N_IN-1: out_bit <= ((acc+term) >= thr), state -> OUT, cnt <= 0, acc <= 0.
- term = in_data, zero-extended to ACC_W (polarity rule under Configuration).
- OUT: in_ready=0, out_valid=1, out_bit stable. On out_ready: state -> ACC.
- Comparison unsigned, ACC_W bits; no saturation needed (width guaranteed sufficient).
- thr register: written whenever thr_we=1, any state. A write takes effect on the comparison of any final beat accepted strictly after the write cycle; if thr_we and the final beat occur in the same cycle, the old thr is used.
- in_data ignored when in_valid=0 or in_ready=0; out_ready ignored in ACC.
- Reset (any state, mid-vector included): state=ACC, cnt=0, acc=0, thr=THR_RST, out_bit=0, out_valid=0, in_ready=1 in the cycle after rst is sampled high; partial vector discarded.

## Timing
- Beat throughput: 1 beat/cycle in ACC.
- Latency: out_valid asserts the cycle after the final beat handshake.
- One bubble per vector: cycle of out handshake has in_ready=0; first beat of next vector accepted the following cycle at earliest.
- Minimum vector period: N_IN+1 cycles with out_ready held high.
- out_valid, out_bit, in_ready are registered-state decodes; no combinational path in_valid->in_ready or out_ready->in_ready.

## Configuration
- TNN_NEURON_POL_EN defined: term = pol[cnt] ? (2^IN_W-1 - in_data) : in_data, i.e. beat cnt is bitwise-inverted when its polarity bit is 1; pol sampled on each accepted beat.
- Undefined: pol port present but unused; term = in_data.

## Structure
- Package tnn_pkg: state enum (ST_ACC, ST_OUT), ACC_W calculation function, counter-width function ($clog2(N_IN)).
- One sub-module, tnn_beat_term: combinational term generation (zero-extend, optional inversion under the macro). Everything else in tnn_seq_neuron.

## Test plan
- Defaults, beats 3,4,4, out_ready=1 -> sum 11, out_valid one cycle after third beat, out_bit=1.
- Beats 3,4,3 -> sum 10, out_bit=0; beats 7,7,7 -> sum 21 (no wrap), out_bit=1.
- out_ready low 5 cycles after decision -> out_valid and out_bit held, in_ready=0 throughout; release -> in_ready=1 next cycle.
- rst pulsed after 2 beats of 7,7 -> next vector 1,1,1 yields sum 3, out_bit=0; thr back to 11.
- thr_we with thr_in=3 during beat 1 of vector 1,1,1 -> out_bit=1; thr_we on final beat cycle -> old thr used.
- TNN_NEURON_POL_EN, pol=3'b001, beats 0,4,4 -> terms 7,4,4, sum 15, out_bit=1; same beats, macro off -> sum 8, out_bit=0.
